// File: rtl/fetch_unit_if.sv
// fetch_unit_if: bundles the fetch unit's program-sequencing, load-port and
// decoder-facing signals. When FETCH_JUMP_COUNT_EN is defined the bundle also
// carries the 16-bit jmp_count statistic driven by the fetch unit.
// master: the side that sequences, loads and decodes (drives start/load/jump).
// slave:  the fetch unit itself.
interface fetch_unit_if #(
  parameter int PC_W    = 10,
  parameter int INSTR_W = 9,
  parameter int LUT_IW  = 4
);
  // program sequencing
  logic               start;
  logic [PC_W-1:0]    prog_len;
  logic               running;
  logic               done;

  // instruction-memory load port
  logic               ld_en;
  logic [PC_W-1:0]    ld_addr;
  logic [INSTR_W-1:0] ld_data;

  // lookup-table load port
  logic               lut_wr_en;
  logic [LUT_IW-1:0]  lut_wr_idx;
  logic [PC_W-1:0]    lut_wr_data;

  // decoder side
  logic               pc_jmp_en;
  logic               pc_jmp_abs;
  logic [LUT_IW-1:0]  LutPointer;
  logic [INSTR_W-1:0] instr;
  logic [PC_W-1:0]    pc;

`ifdef FETCH_JUMP_COUNT_EN
  logic [15:0]        jmp_count;

  modport master (
    output start, prog_len, ld_en, ld_addr, ld_data,
           lut_wr_en, lut_wr_idx, lut_wr_data,
           pc_jmp_en, pc_jmp_abs, LutPointer,
    input  instr, pc, running, done, jmp_count
  );

  modport slave (
    input  start, prog_len, ld_en, ld_addr, ld_data,
           lut_wr_en, lut_wr_idx, lut_wr_data,
           pc_jmp_en, pc_jmp_abs, LutPointer,
    output instr, pc, running, done, jmp_count
  );
`else
  modport master (
    output start, prog_len, ld_en, ld_addr, ld_data,
           lut_wr_en, lut_wr_idx, lut_wr_data,
           pc_jmp_en, pc_jmp_abs, LutPointer,
    input  instr, pc, running, done
  );

  modport slave (
    input  start, prog_len, ld_en, ld_addr, ld_data,
           lut_wr_en, lut_wr_idx, lut_wr_data,
           pc_jmp_en, pc_jmp_abs, LutPointer,
    output instr, pc, running, done
  );
`endif

endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch end of the control path. Holds the program
// counter, the instruction memory and the jump-target lookup table, sequences
// a program run (IDLE -> RUN -> DONE) and presents imem[pc] to the decoder
// combinationally so decode/execute completes in the same cycle.
// Optional feature: define FETCH_JUMP_COUNT_EN to add a saturating 16-bit
// count of jump requests seen during the current run (bus.jmp_count).
module fetch_unit #(
  parameter int PC_W    = 10,
  parameter int INSTR_W = 9,
  parameter int LUT_N   = 16
) (
  input  logic        clk,
  input  logic        reset,
  fetch_unit_if.slave bus
);

  localparam int LUT_IW = $clog2(LUT_N);
  localparam int DEPTH  = 2 ** PC_W;
  // Next-PC arithmetic is done one bit wider so a sequential step past the
  // top address shows up as a value >= any length instead of wrapping to 0.
  localparam logic [PC_W:0] ONE_EXT = (PC_W + 1)'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t state_reg;
  state_t state_next;

  logic [PC_W-1:0] pc_reg;
  logic [PC_W-1:0] pc_next;
  logic [PC_W-1:0] len_reg;
  logic [PC_W-1:0] len_next;

  // Instruction memory is read asynchronously (the decoder needs the word in
  // the same cycle as the PC), so this maps to distributed RAM.
  logic [INSTR_W-1:0] imem [DEPTH];
  logic [PC_W-1:0]    lut_rd [LUT_N];

  logic               load_open;
  logic               start_accept;
  logic [PC_W-1:0]    lut_entry;
  logic [PC_W-1:0]    rel_target;
  logic [PC_W:0]      target_ext;
  logic               halt;

  // Loads and starts are only honoured outside a run.
  assign load_open    = (state_reg != ST_RUN);
  assign start_accept = bus.start && load_open;

  // ------------------------------------------------------------------
  // Storage
  // ------------------------------------------------------------------

  // Instruction-memory write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (bus.ld_en && load_open) begin
      imem[bus.ld_addr] <= bus.ld_data;
    end
  end

  generate
    for (genvar gi = 0; gi < LUT_N; gi++) begin : g_lut
      logic [PC_W-1:0] entry_reg;

      // One lookup-table entry, written when its index is addressed; no reset.
      always_ff @(posedge clk) begin
        if (bus.lut_wr_en && load_open && (bus.lut_wr_idx == LUT_IW'(gi))) begin
          entry_reg <= bus.lut_wr_data;
        end
      end

      assign lut_rd[gi] = entry_reg;
    end
  endgenerate

  // ------------------------------------------------------------------
  // Next-PC and halt detection
  // ------------------------------------------------------------------

  // Candidate next PC for the current RUN cycle and whether it ends the run.
  always_comb begin
    lut_entry  = lut_rd[bus.LutPointer];
    // Adding the PC_W-bit entry modulo 2**PC_W is the same as adding it as a
    // signed two's-complement offset.
    rel_target = pc_reg + lut_entry;
    target_ext = {1'b0, pc_reg} + ONE_EXT;
    if (bus.pc_jmp_en) begin
      if (bus.pc_jmp_abs) begin
        target_ext = {1'b0, lut_entry};
      end else begin
        target_ext = {1'b0, rel_target};
      end
    end
    // Covers len 0, running off the end, out-of-range jump targets and the
    // carry out of the top address.
    halt = (target_ext >= {1'b0, len_reg});
  end

  // PC and latched length: restart on an accepted start, advance while running.
  always_comb begin
    pc_next  = pc_reg;
    len_next = len_reg;
    if (start_accept) begin
      pc_next  = '0;
      len_next = bus.prog_len;
    end else if ((state_reg == ST_RUN) && !halt) begin
      pc_next = target_ext[PC_W-1:0];
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg  <= '0;
      len_reg <= '0;
    end else begin
      pc_reg  <= pc_next;
      len_reg <= len_next;
    end
  end

  // ------------------------------------------------------------------
  // Run sequencing FSM
  // ------------------------------------------------------------------

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: start launches a run from IDLE or DONE, halt ends it.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (bus.start) state_next = ST_RUN;
      ST_RUN:  if (halt)      state_next = ST_DONE;
      ST_DONE: if (bus.start) state_next = ST_RUN;
      default:                state_next = ST_IDLE;
    endcase
  end

  // Outputs: the fetched word is shown only while running; otherwise the
  // decoder sees opcode 0 (cmp), which has no side effects.
  always_comb begin
    bus.instr   = '0;
    bus.running = 1'b0;
    bus.done    = 1'b0;
    bus.pc      = pc_reg;
    case (state_reg)
      ST_RUN: begin
        bus.instr   = imem[pc_reg];
        bus.running = 1'b1;
      end
      ST_DONE: bus.done = 1'b1;
      default: ;
    endcase
  end

`ifdef FETCH_JUMP_COUNT_EN
  // ------------------------------------------------------------------
  // Jump statistic
  // ------------------------------------------------------------------
  logic [15:0] jmp_count_reg;

  // Counts jump requests per run, including one that halts; saturates.
  always_ff @(posedge clk) begin
    if (reset) begin
      jmp_count_reg <= '0;
    end else if (start_accept) begin
      jmp_count_reg <= '0;
    end else if ((state_reg == ST_RUN) && bus.pc_jmp_en && (jmp_count_reg != 16'hFFFF)) begin
      jmp_count_reg <= jmp_count_reg + 16'd1;
    end
  end

  assign bus.jmp_count = jmp_count_reg;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table-driven directed runs, hand-written corner sequences
// and a randomized phase compared against a behavioural model of fetch_unit.
// FETCH_JUMP_COUNT_EN, when defined, also enables jmp_count checks.
module tb_fetch_unit;

  localparam int PC_W    = 10;
  localparam int INSTR_W = 9;
  localparam int LUT_N   = 16;

  logic clk = 1'b0;
  logic reset;

  fetch_unit_if #(.PC_W(PC_W), .INSTR_W(INSTR_W), .LUT_IW(4)) bus ();

  fetch_unit #(.PC_W(PC_W), .INSTR_W(INSTR_W), .LUT_N(LUT_N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // behavioural model state
  bit m_running;
  bit m_done;
  int m_pc;
  int m_len;
  int m_imem [1024];
  int m_lut  [16];
`ifdef FETCH_JUMP_COUNT_EN
  int m_jc;
`endif

  typedef struct {
    bit do_start;
    int len;
    bit jen;
    bit jabs;
    int ptr;
    int epc;
    int einstr;
    bit erun;
    bit edone;
    int ejc;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(input bit st, input int len, input bit jen, input bit jabs,
                              input int ptr, input int epc, input int ein, input bit erun,
                              input bit edone, input int ejc);
    vec_t v;
    v.do_start = st;  v.len = len;  v.jen = jen;  v.jabs = jabs;  v.ptr = ptr;
    v.epc = epc;  v.einstr = ein;  v.erun = erun;  v.edone = edone;  v.ejc = ejc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input int addr, input int data);
    bus.ld_en   = 1'b1;
    bus.ld_addr = 10'(addr);
    bus.ld_data = 9'(data);
    step();
    bus.ld_en   = 1'b0;
    m_imem[addr] = data;
  endtask

  task automatic load_lut(input int idx, input int data);
    bus.lut_wr_en   = 1'b1;
    bus.lut_wr_idx  = 4'(idx);
    bus.lut_wr_data = 10'(data);
    step();
    bus.lut_wr_en   = 1'b0;
    m_lut[idx] = data;
  endtask

  task automatic pulse_start(input int len);
    bus.start    = 1'b1;
    bus.prog_len = 10'(len);
    step();
    bus.start    = 1'b0;
    bus.prog_len = '0;
  endtask

  task automatic wait_done(input string tag, input int limit);
    int n = 0;
    while (bus.done !== 1'b1 && n < limit) begin
      step();
      n++;
    end
    check({tag, "_done"}, bus.done, 1);
  endtask

  // Spec-level model of one clock edge.
  task automatic model_step(input bit rst, input bit st, input int len, input bit jen,
                            input bit jabs, input int ptr, input bit ld, input int la,
                            input int ldd, input bit lw, input int li, input int lwd);
    int nxt;
    int off;
    if (rst) begin
      m_running = 0;  m_done = 0;  m_pc = 0;
`ifdef FETCH_JUMP_COUNT_EN
      m_jc = 0;
`endif
    end else if (!m_running) begin
      if (ld) m_imem[la] = ldd;
      if (lw) m_lut[li]  = lwd;
      if (st) begin
        m_running = 1;  m_done = 0;  m_pc = 0;  m_len = len;
`ifdef FETCH_JUMP_COUNT_EN
        m_jc = 0;
`endif
      end
    end else begin
`ifdef FETCH_JUMP_COUNT_EN
      if (jen && m_jc < 65535) m_jc = m_jc + 1;
`endif
      if (!jen) begin
        nxt = m_pc + 1;
      end else if (jabs) begin
        nxt = m_lut[ptr];
      end else begin
        off = (m_lut[ptr] >= 512) ? m_lut[ptr] - 1024 : m_lut[ptr];
        nxt = (m_pc + off + 1024) % 1024;
      end
      if (nxt >= m_len) begin
        m_running = 0;
        m_done    = 1;
      end else begin
        m_pc = nxt;
      end
    end
  endtask

  initial begin
    int n;
    int last;
    int bad;
    bit r_rst, r_st, r_jen, r_jabs, r_ld, r_lw;
    int r_len, r_ptr, r_la, r_ldd, r_li, r_lwd;
    int run_len;

    reset = 1'b1;
    bus.start = 0;  bus.prog_len = '0;  bus.ld_en = 0;  bus.ld_addr = '0;  bus.ld_data = '0;
    bus.lut_wr_en = 0;  bus.lut_wr_idx = '0;  bus.lut_wr_data = '0;
    bus.pc_jmp_en = 0;  bus.pc_jmp_abs = 0;  bus.LutPointer = '0;

    step();
    step();
    check("rst_pc", bus.pc, 0);
    check("rst_running", bus.running, 0);
    check("rst_done", bus.done, 0);
    check("rst_instr", bus.instr, 0);
`ifdef FETCH_JUMP_COUNT_EN
    check("rst_jc", bus.jmp_count, 0);
`endif
    reset = 1'b0;

    // program: imem[i] = 0x40 + i; lut[5] written twice back to back (7 wins)
    for (int i = 0; i < 16; i++) load_word(i, 'h40 + i);
    load_lut(5, 1);
    load_lut(5, 7);
    load_lut(3, 'h3FE);

    // run A: 4 sequential instructions
    tv.push_back(mk(1, 4, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int p = 0; p < 4; p++) tv.push_back(mk(0, 0, 0, 0, 0, p, 'h40 + p, 1, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 3, 0, 0, 1, 0));
    // run B: absolute jump at pc 2 via lut[5] = 7, len 10
    tv.push_back(mk(1, 10, 0, 0, 0, 3, 0, 0, 1, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 'h40, 1, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 1, 'h41, 1, 0, 0));
    tv.push_back(mk(0, 0, 1, 1, 5, 2, 'h42, 1, 0, 0));
    for (int p = 7; p < 10; p++) tv.push_back(mk(0, 0, 0, 0, 0, p, 'h40 + p, 1, 0, 1));
    tv.push_back(mk(0, 0, 0, 0, 0, 9, 0, 0, 1, 1));
    // run C: relative jump -2 at pc 6 via lut[3]; a start at pc 2 is ignored
    tv.push_back(mk(1, 10, 0, 0, 0, 9, 0, 0, 1, 1));
    for (int p = 0; p < 6; p++) tv.push_back(mk(p == 2, 2, 0, 0, 0, p, 'h40 + p, 1, 0, 0));
    tv.push_back(mk(0, 0, 1, 0, 3, 6, 'h46, 1, 0, 0));
    for (int p = 4; p < 10; p++) tv.push_back(mk(0, 0, 0, 0, 0, p, 'h40 + p, 1, 0, 1));
    tv.push_back(mk(0, 0, 0, 0, 0, 9, 0, 0, 1, 1));

    for (int i = 0; i < tv.size(); i++) begin
      bus.start      = tv[i].do_start;
      bus.prog_len   = 10'(tv[i].len);
      bus.pc_jmp_en  = tv[i].jen;
      bus.pc_jmp_abs = tv[i].jabs;
      bus.LutPointer = 4'(tv[i].ptr);
      check($sformatf("tbl%0d_pc", i), bus.pc, tv[i].epc);
      check($sformatf("tbl%0d_instr", i), bus.instr, tv[i].einstr);
      check($sformatf("tbl%0d_running", i), bus.running, tv[i].erun);
      check($sformatf("tbl%0d_done", i), bus.done, tv[i].edone);
`ifdef FETCH_JUMP_COUNT_EN
      check($sformatf("tbl%0d_jc", i), bus.jmp_count, tv[i].ejc);
`endif
      step();
    end
    bus.start = 0;  bus.pc_jmp_en = 0;  bus.pc_jmp_abs = 0;  bus.prog_len = '0;

    // prog_len 0: exactly one RUN cycle, then DONE
    pulse_start(0);
    check("len0_running", bus.running, 1);
    check("len0_instr", bus.instr, 'h40);
    step();
    check("len0_done", bus.done, 1);
    check("len0_instr_after", bus.instr, 0);
    check("len0_pc", bus.pc, 0);

    // start together with a write: the new word is fetched in the first RUN cycle
    bus.ld_en = 1;  bus.ld_addr = '0;  bus.ld_data = 9'h155;
    pulse_start(1);
    bus.ld_en = 0;
    check("startld_instr", bus.instr, 'h155);
    step();
    check("startld_done", bus.done, 1);
    load_word(0, 'h40);

    // writes during RUN are ignored (imem[0] and lut[5] keep their values)
    pulse_start(10);
    check("runld_running", bus.running, 1);
    bus.ld_en = 1;  bus.ld_addr = '0;  bus.ld_data = 9'h1AA;
    bus.lut_wr_en = 1;  bus.lut_wr_idx = 4'd5;  bus.lut_wr_data = '0;
    step();
    bus.ld_en = 0;  bus.lut_wr_en = 0;
    wait_done("runld", 20);
    pulse_start(10);
    check("runld_imem0_kept", bus.instr, 'h40);
    bus.pc_jmp_en = 1;  bus.pc_jmp_abs = 1;  bus.LutPointer = 4'd5;
    step();
    bus.pc_jmp_en = 0;  bus.pc_jmp_abs = 0;
    check("runld_lut5_kept", bus.pc, 7);
    wait_done("runld2", 20);

    // reset at pc 5 mid-run, then re-run the preserved program
    pulse_start(10);
    n = 0;
    while (bus.pc != 10'd5 && n < 20) begin step(); n++; end
    check("midrst_reach_pc5", bus.pc, 5);
    reset = 1;
    step();
    reset = 0;
    check("midrst_pc", bus.pc, 0);
    check("midrst_running", bus.running, 0);
    check("midrst_done", bus.done, 0);
    check("midrst_instr", bus.instr, 0);
    pulse_start(4);
    check("midrst_rerun_instr", bus.instr, 'h40);
    check("midrst_rerun_running", bus.running, 1);
    wait_done("midrst", 10);
    check("midrst_final_pc", bus.pc, 3);

    // longest program: sequential to the top without wrapping
    pulse_start(1023);
    n = 0;  last = -1;  bad = 0;
    while (bus.running === 1'b1 && n < 1100) begin
      if (int'(bus.pc) != last + 1) bad++;
      last = int'(bus.pc);
      step();
      n++;
    end
    check("long_cycles", n, 1023);
    check("long_seq_errors", bad, 0);
    check("long_done", bus.done, 1);
    check("long_final_pc", bus.pc, 1022);

    // randomized phase against the model
    for (int i = 0; i < 64; i++) load_word(i, $urandom_range(0, 511));
    for (int i = 0; i < 16; i++)
      load_lut(i, ($urandom_range(0, 1) == 1) ? $urandom_range(0, 63) : 1024 - $urandom_range(1, 4));
    reset = 1;
    step();
    reset = 0;
    model_step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_len = 0;
    for (int c = 0; c < 2500; c++) begin
      r_rst  = (run_len > 150) || ($urandom_range(0, 299) == 0);
      r_st   = ($urandom_range(0, 9) == 0);
      r_len  = $urandom_range(0, 48);
      r_jen  = ($urandom_range(0, 3) == 0);
      r_jabs = $urandom_range(0, 1) == 1;
      r_ptr  = $urandom_range(0, 15);
      r_ld   = ($urandom_range(0, 3) == 0) && !r_rst;
      r_la   = $urandom_range(0, 63);
      r_ldd  = $urandom_range(0, 511);
      r_lw   = ($urandom_range(0, 7) == 0) && !r_rst;
      r_li   = $urandom_range(0, 15);
      r_lwd  = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 63) : 1024 - $urandom_range(1, 4);
      reset = r_rst;  bus.start = r_st;  bus.prog_len = 10'(r_len);
      bus.pc_jmp_en = r_jen;  bus.pc_jmp_abs = r_jabs;  bus.LutPointer = 4'(r_ptr);
      bus.ld_en = r_ld;  bus.ld_addr = 10'(r_la);  bus.ld_data = 9'(r_ldd);
      bus.lut_wr_en = r_lw;  bus.lut_wr_idx = 4'(r_li);  bus.lut_wr_data = 10'(r_lwd);
      check($sformatf("rand%0d_pc", c), bus.pc, m_pc);
      check($sformatf("rand%0d_instr", c), bus.instr, m_running ? m_imem[m_pc] : 0);
      check($sformatf("rand%0d_running", c), bus.running, m_running);
      check($sformatf("rand%0d_done", c), bus.done, m_done);
`ifdef FETCH_JUMP_COUNT_EN
      check($sformatf("rand%0d_jc", c), bus.jmp_count, m_jc);
`endif
      step();
      model_step(r_rst, r_st, r_len, r_jen, r_jabs, r_ptr, r_ld, r_la, r_ldd, r_lw, r_li, r_lwd);
      run_len = m_running ? run_len + 1 : 0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no summary, required summary before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
